// File: rtl/spi_regfile_if.sv
// SPI pin bundle between a bus master (host) and the register-file slave.
interface spi_regfile_if;
  logic spi_clk;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_ss,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_ss,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file. The SPI pins are oversampled in the
// input_clk domain. Commands: 0x01 addr = burst read, 0x02 addr = burst write.
// Addresses auto-increment and wrap at NREGS.
module spi_regfile #(
  parameter int NREGS       = 16,
  parameter int DATA_BYTES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              input_clk,
  input  logic                              reset,
  spi_regfile_if.slave                      spi,
  output logic [NREGS*8*DATA_BYTES-1:0]     write_regs,
  input  logic [NREGS*8*DATA_BYTES-1:0]     read_regs,
  output logic [NREGS-1:0]                  wr_strobe,
  output logic                              busy
);
  localparam int REG_W = 8 * DATA_BYTES;
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int BW    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_RADDR  = 3'd1;
  localparam logic [2:0] ST_WADDR  = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  // Synchroniser chains; valid_sync_reg tracks when the chains hold real pin samples.
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] valid_sync_reg;

  logic [2:0]       state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       rx_reg;
  logic [BW-1:0]    byte_idx_reg;
  logic [AW-1:0]    addr_reg;
  logic [REG_W-1:0] wbuf_reg;
  logic [REG_W-1:0] tx_reg;
  logic             first_fall_reg;
  logic             armed_reg;
  logic             sclk_prev_reg;
  logic             miso_reg;

  logic             sclk_s;
  logic             ss_s;
  logic             mosi_s;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             selected;
  logic [7:0]       rx_byte;
  logic             byte_done;
  logic             last_byte;
  logic [AW-1:0]    addr_inc;
  logic [AW-1:0]    rx_addr;
  logic [AW-1:0]    rx_addr_inc;
  logic             addr_ok;
  logic [REG_W-1:0] wbuf_next;
  logic             commit;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  // After a reset the bus stays dead until slave select has been seen high.
  assign selected  = armed_reg & ~ss_s;
  assign rx_byte   = {rx_reg[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
  assign last_byte = (byte_idx_reg == BW'(DATA_BYTES - 1));
  assign addr_inc  = (addr_reg == AW'(NREGS - 1)) ? '0 : addr_reg + 1'b1;
  assign rx_addr   = rx_byte[AW-1:0];
  assign rx_addr_inc = (rx_addr == AW'(NREGS - 1)) ? '0 : rx_addr + 1'b1;
  assign addr_ok   = ({1'b0, rx_byte} < 9'(NREGS));
  assign wbuf_next = (wbuf_reg << 8) | REG_W'(rx_byte);
  assign commit    = selected && byte_done && (state_reg == ST_WDATA) && last_byte;

  assign busy         = ~ss_s;
  assign spi.spi_miso = miso_reg;

  // Pin synchronisers; slave select idles deasserted so busy is 0 out of reset.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sclk_sync_reg  <= '0;
      ss_sync_reg    <= '1;
      mosi_sync_reg  <= '0;
      valid_sync_reg <= '0;
    end else begin
      sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], spi.spi_clk};
      ss_sync_reg    <= {ss_sync_reg[SYNC_STAGES-2:0], spi.spi_ss};
      mosi_sync_reg  <= {mosi_sync_reg[SYNC_STAGES-2:0], spi.spi_mosi};
      valid_sync_reg <= {valid_sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Command/address FSM, bit and byte counters, and the MISO shifter.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_CMD;
      bit_cnt_reg    <= '0;
      rx_reg         <= '0;
      byte_idx_reg   <= '0;
      addr_reg       <= '0;
      wbuf_reg       <= '0;
      tx_reg         <= '0;
      first_fall_reg <= 1'b0;
      armed_reg      <= 1'b0;
      sclk_prev_reg  <= 1'b0;
      miso_reg       <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      if (valid_sync_reg[SYNC_STAGES-1] && ss_s) begin
        armed_reg <= 1'b1;
      end
      if (!selected) begin
        // Deselect wins over a same-cycle byte completion: nothing commits.
        state_reg      <= ST_CMD;
        bit_cnt_reg    <= '0;
        byte_idx_reg   <= '0;
        first_fall_reg <= 1'b0;
        miso_reg       <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          rx_reg      <= rx_byte;
          if (byte_done) begin
            case (state_reg)
              ST_CMD: begin
                if (rx_byte == 8'h01)      state_reg <= ST_RADDR;
                else if (rx_byte == 8'h02) state_reg <= ST_WADDR;
                else                       state_reg <= ST_IGNORE;
              end
              ST_RADDR: begin
                if (addr_ok) begin
                  tx_reg         <= read_regs[rx_addr*REG_W +: REG_W];
                  addr_reg       <= rx_addr_inc;
                  byte_idx_reg   <= '0;
                  first_fall_reg <= 1'b1;
                  state_reg      <= ST_RDATA;
                end else begin
                  state_reg <= ST_IGNORE;
                end
              end
              ST_WADDR: begin
                if (addr_ok) begin
                  addr_reg     <= rx_addr;
                  byte_idx_reg <= '0;
                  state_reg    <= ST_WDATA;
                end else begin
                  state_reg <= ST_IGNORE;
                end
              end
              ST_WDATA: begin
                wbuf_reg <= wbuf_next;
                if (last_byte) begin
                  addr_reg     <= addr_inc;
                  byte_idx_reg <= '0;
                end else begin
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                end
              end
              ST_RDATA: begin
                if (last_byte) begin
                  // Whole-word snapshot keeps multi-byte reads coherent.
                  tx_reg         <= read_regs[addr_reg*REG_W +: REG_W];
                  addr_reg       <= addr_inc;
                  byte_idx_reg   <= '0;
                  first_fall_reg <= 1'b1;
                end else begin
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                end
              end
              default: state_reg <= ST_IGNORE;
            endcase
          end
        end
        if (sclk_fall) begin
          if (state_reg == ST_RDATA) begin
            if (first_fall_reg) begin
              miso_reg       <= tx_reg[REG_W-1];
              first_fall_reg <= 1'b0;
            end else begin
              tx_reg   <= tx_reg << 1;
              miso_reg <= tx_reg[REG_W-2];
            end
          end else begin
            miso_reg <= 1'b0;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [REG_W-1:0] word_reg;
      logic             strobe_reg;
      logic             hit;

      assign hit = commit && (addr_reg == AW'(gi));

      // Register word and its one-cycle write strobe.
      always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
          word_reg   <= '0;
          strobe_reg <= 1'b0;
        end else begin
          strobe_reg <= hit;
          if (hit) begin
            word_reg <= wbuf_next;
          end
        end
      end

      assign write_regs[gi*REG_W +: REG_W] = word_reg;
      assign wr_strobe[gi]                 = strobe_reg;
    end
  endgenerate
endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: bit-banged SPI host, MISO scoreboard,
// strobe log and a register model.
module tb_spi_regfile;
  localparam int NREGS = 16;
  localparam int DB    = 2;
  localparam int RW    = 8 * DB;
  localparam time HALF = 80ns;

  logic                clk;
  logic                reset;
  logic [NREGS*RW-1:0] write_regs;
  logic [NREGS*RW-1:0] read_regs;
  logic [NREGS-1:0]    wr_strobe;
  logic                busy;

  spi_regfile_if bus ();

  spi_regfile #(.NREGS(NREGS), .DATA_BYTES(DB), .SYNC_STAGES(2)) dut (
    .input_clk  (clk),
    .reset      (reset),
    .spi        (bus),
    .write_regs (write_regs),
    .read_regs  (read_regs),
    .wr_strobe  (wr_strobe),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]    exp_q[$];
  logic [15:0]   strobe_log[$];
  logic [RW-1:0] model [NREGS];

  // Record every cycle that shows any strobe, so a stretched pulse is visible.
  always @(negedge clk) begin
    if (wr_strobe !== '0) strobe_log.push_back(wr_strobe);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < NREGS; i++) f[i*RW +: RW] = model[i];
    return f;
  endfunction

  task automatic check_strobes(input string tag, input int n, input logic [15:0] s0, input logic [15:0] s1);
    logic [15:0] o0;
    logic [15:0] o1;
    check({tag, "_count"}, strobe_log.size(), n);
    if (n > 0) begin
      o0 = (strobe_log.size() > 0) ? strobe_log[0] : 16'hxxxx;
      check({tag, "_first"}, o0, s0);
    end
    if (n > 1) begin
      o1 = (strobe_log.size() > 1) ? strobe_log[1] : 16'hxxxx;
      check({tag, "_second"}, o1, s1);
    end
    strobe_log.delete();
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = b[i];
      #HALF;
      bus.spi_clk = 1'b1;
      rx = {rx[6:0], bus.spi_miso};
      #HALF;
      bus.spi_clk = 1'b0;
    end
  endtask

  // Push the expected MISO byte, clock the byte out, pop and compare.
  task automatic xfer(input string tag, input logic [7:0] b, input logic [7:0] exp_miso);
    logic [7:0] rx;
    logic [7:0] e;
    exp_q.push_back(exp_miso);
    spi_bits(b, 8, rx);
    e = exp_q.pop_front();
    check(tag, rx, e);
  endtask

  task automatic ss_low();
    @(negedge clk);
    bus.spi_ss = 1'b0;
    #HALF;
  endtask

  task automatic ss_high();
    #HALF;
    bus.spi_ss = 1'b1;
    #100ns;
  endtask

  initial begin
    logic [7:0] junk;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    reset        = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    read_regs    = '0;
    #52ns;
    check("rst_regs", write_regs, '0);
    check("rst_strobe", wr_strobe, '0);
    check("rst_miso", bus.spi_miso, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #100ns;

    // Single write 02 03 AB CD
    ss_low();
    check("wr_busy", busy, 1'b1);
    xfer("wr_cmd", 8'h02, 8'h00);
    xfer("wr_addr", 8'h03, 8'h00);
    xfer("wr_d0", 8'hAB, 8'h00);
    xfer("wr_d1", 8'hCD, 8'h00);
    ss_high();
    model[3] = 16'hABCD;
    check("wr_regs", write_regs, model_flat());
    check_strobes("wr_strb", 1, 16'h0008, 16'h0000);
    check("wr_idle_busy", busy, 1'b0);

    // Burst read 01 05 + 4 dummies
    read_regs[5*RW +: RW] = 16'h1234;
    read_regs[6*RW +: RW] = 16'h5678;
    ss_low();
    xfer("rd_cmd", 8'h01, 8'h00);
    xfer("rd_addr", 8'h05, 8'h00);
    xfer("rd_b0", 8'hFF, 8'h12);
    xfer("rd_b1", 8'h00, 8'h34);
    xfer("rd_b2", 8'hA5, 8'h56);
    xfer("rd_b3", 8'h5A, 8'h78);
    ss_high();
    check_strobes("rd_strb", 0, 16'h0, 16'h0);

    // Wrapping burst write 02 0F 11 11 22 22
    ss_low();
    xfer("wrap_cmd", 8'h02, 8'h00);
    xfer("wrap_addr", 8'h0F, 8'h00);
    xfer("wrap_d0", 8'h11, 8'h00);
    xfer("wrap_d1", 8'h11, 8'h00);
    xfer("wrap_d2", 8'h22, 8'h00);
    xfer("wrap_d3", 8'h22, 8'h00);
    ss_high();
    model[15] = 16'h1111;
    model[0]  = 16'h2222;
    check("wrap_regs", write_regs, model_flat());
    check_strobes("wrap_strb", 2, 16'h8000, 16'h0001);

    // Abort mid-word: 02 02 AA then 4 bits
    ss_low();
    xfer("ab_cmd", 8'h02, 8'h00);
    xfer("ab_addr", 8'h02, 8'h00);
    xfer("ab_d0", 8'hAA, 8'h00);
    spi_bits(8'hBB, 4, junk);
    ss_high();
    check("ab_regs", write_regs, model_flat());
    check_strobes("ab_strb", 0, 16'h0, 16'h0);
    ss_low();
    xfer("ab2_cmd", 8'h02, 8'h00);
    xfer("ab2_addr", 8'h02, 8'h00);
    xfer("ab2_d0", 8'hBE, 8'h00);
    xfer("ab2_d1", 8'hEF, 8'h00);
    ss_high();
    model[2] = 16'hBEEF;
    check("ab2_regs", write_regs, model_flat());
    check_strobes("ab2_strb", 1, 16'h0004, 16'h0);

    // Invalid command, then out-of-range read and write addresses
    read_regs = '1;
    ss_low();
    xfer("inv_cmd", 8'h7E, 8'h00);
    check("inv_busy", busy, 1'b1);
    xfer("inv_b1", 8'h02, 8'h00);
    xfer("inv_b2", 8'h03, 8'h00);
    xfer("inv_b3", 8'h55, 8'h00);
    ss_high();
    ss_low();
    xfer("inv_rcmd", 8'h01, 8'h00);
    xfer("inv_raddr", 8'h20, 8'h00);
    xfer("inv_rb0", 8'h00, 8'h00);
    ss_high();
    ss_low();
    xfer("inv_wcmd", 8'h02, 8'h00);
    xfer("inv_waddr", 8'h20, 8'h00);
    xfer("inv_wb0", 8'h11, 8'h00);
    xfer("inv_wb1", 8'h22, 8'h00);
    ss_high();
    check("inv_regs", write_regs, model_flat());
    check_strobes("inv_strb", 0, 16'h0, 16'h0);

    // Reset during a read while MISO is driving a 1
    ss_low();
    xfer("mr_cmd", 8'h01, 8'h00);
    xfer("mr_addr", 8'h05, 8'h00);
    spi_bits(8'h00, 3, junk);
    #60ns;
    check("mr_miso_pre", bus.spi_miso, 1'b1);
    #3ns;
    reset = 1'b1;
    #1ns;
    check("mr_regs", write_regs, '0);
    check("mr_strobe", wr_strobe, '0);
    check("mr_miso", bus.spi_miso, 1'b0);
    check("mr_busy", busy, 1'b0);
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    #100ns;
    // Still selected from before the reset: must be ignored.
    xfer("mr_dead0", 8'h02, 8'h00);
    xfer("mr_dead1", 8'h03, 8'h00);
    xfer("mr_dead2", 8'hAB, 8'h00);
    xfer("mr_dead3", 8'hCD, 8'h00);
    ss_high();
    check("mr_dead_regs", write_regs, model_flat());
    check_strobes("mr_dead_strb", 0, 16'h0, 16'h0);
    ss_low();
    xfer("mr_new_cmd", 8'h02, 8'h00);
    xfer("mr_new_addr", 8'h01, 8'h00);
    xfer("mr_new_d0", 8'h12, 8'h00);
    xfer("mr_new_d1", 8'h34, 8'h00);
    ss_high();
    model[1] = 16'h1234;
    check("mr_new_regs", write_regs, model_flat());
    check_strobes("mr_new_strb", 1, 16'h0002, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
